eq_selftest: RTL and testbench
==============================

Name: eq_selftest

Overview:
Built-in self-test driver for the ALU equality comparators (1-bit/2-bit eq cells and wider compositions). Sits on the input side of the comparator under test. It generates every operand pair exhaustively, samples the comparator's equality flag, checks it against a golden a==b, and reports pass/fail, an error count and the first failing vector. It is intended for on-board checking on the Basys 3, with start wired to a debounced button and results shown on LEDs.

Parameters:
WIDTH, 2, operand width of the comparator under test (1..8)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a test run; level-sampled; ignored while busy
dut_a  output  WIDTH  operand A driven to the comparator
dut_b  output  WIDTH  operand B driven to the comparator
dut_eq  input  1  comparator equality result (combinational from dut_a/dut_b)
busy  output  1  run in progress
done  output  1  run complete; held until next start or reset
pass  output  1  valid when done; 1 iff err_count==0
err_count  output  2*WIDTH+1  number of mismatching vectors, saturating at all-ones
fail_a  output  WIDTH  dut_a of first mismatch (0 if none)
fail_b  output  WIDTH  dut_b of first mismatch (0 if none)

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n). All outputs are registered.
- On rst_n low: state=IDLE, idx=0, and every output is 0 (dut_a, dut_b, busy, done, pass, err_count, fail_a, fail_b). Reset mid-run aborts immediately with no partial result retained.
- Vector index idx is 2*WIDTH bits wide. dut_a=idx[2W-1:W] and dut_b=idx[W-1:0], both driven directly from registers.
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE or DONE with start=1:
  - next state DRIVE; idx=0; err_count=0; fail_a=fail_b=0; done=0; pass=0; busy=1.
- DRIVE:
  - Operands are stable for a full cycle so dut_eq can settle.
  - Next state CHECK unconditionally.
- CHECK:
  - Sample dut_eq and compare with the golden (dut_a==dut_b).
  - On mismatch: err_count+=1, saturating.
  - If this is the first mismatch (err_count==0 before the increment), capture fail_a/fail_b from the current dut_a/dut_b.
  - If idx==all-ones: next state DONE, busy=0, done=1, pass=(final err_count==0). The final vector's error is included in pass.
  - Otherwise: idx+=1 and next state DRIVE.
- DONE: hold all results and dut_a/dut_b at their last value until start or reset.
- Latency: busy is high for exactly 2*2^(2W) cycles (32 for W=2). done rises on the edge after the last CHECK.
- start while busy is ignored and has no effect on idx or the counts.
- start held high continuously means DONE restarts on the next cycle, so done pulses for one cycle per run.
- dut_eq is X-free in normal use. An X on dut_eq in CHECK is counted as a mismatch, so the golden compare uses case-equality semantics.

Decomposition:
- Shared package: FSM state encoding constants (IDLE=2'd0, DRIVE=2'd1, CHECK=2'd2, DONE=2'd3) and a function for err_count width (2*WIDTH+1).
- No sub-module is required; the golden compare is inline.
- Top-level on-board use instantiates eq_selftest next to the comparator under test.

Test Plan:
- W=2, correct comparator, start pulse 1 cycle -> busy for 32 cycles, then done=1, pass=1, err_count=0, fail_a=fail_b=0.
- dut_eq stuck 0 -> err_count=4, pass=0, fail_a=0, fail_b=0.
- dut_eq stuck 1 -> err_count=12, fail_a=0, fail_b=1.
- dut_eq inverted -> err_count=16, first fail (0,0).
- Assert start again at cycle 10 of a run -> no effect; done still at cycle 33 with correct counts.
- rst_n low at cycle 15 of a faulty run -> all outputs 0 asynchronously; a fresh start then gives full correct results (no carry-over).

Source files
------------

// File: rtl/eq_selftest_pkg.sv
// Shared definitions for the equality-comparator self-test driver.
package eq_selftest_pkg;

    // Run sequencing: each vector spends one cycle settling and one being checked.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Error counter width: one bit wider than the vector index, so it can
    // hold the count of every vector failing without wrapping.
    function automatic int unsigned err_width(input int unsigned w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/eq_selftest.sv
// Exhaustive self-test driver for an equality comparator: walks every
// operand pair, checks dut_eq against a golden a==b and records the results.
module eq_selftest
    import eq_selftest_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic [WIDTH-1:0]              dut_a,
    output logic [WIDTH-1:0]              dut_b,
    input  logic                          dut_eq,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [err_width(WIDTH)-1:0]   err_count,
    output logic [WIDTH-1:0]              fail_a,
    output logic [WIDTH-1:0]              fail_b
);

    localparam int unsigned IW = 2 * WIDTH;
    localparam int unsigned EW = err_width(WIDTH);

    state_t             state, state_d;
    logic [IW-1:0]      idx, idx_d;
    logic               busy_d, done_d, pass_d;
    logic [EW-1:0]      err_d;
    logic [WIDTH-1:0]   fail_a_d, fail_b_d;
    logic               mismatch;

    // Operands come straight from the index register halves.
    assign dut_a = idx[IW-1:WIDTH];
    assign dut_b = idx[WIDTH-1:0];

    // Next-state and result update; an X on dut_eq counts as a mismatch.
    always_comb begin
        state_d  = state;
        idx_d    = idx;
        busy_d   = busy;
        done_d   = done;
        pass_d   = pass;
        err_d    = err_count;
        fail_a_d = fail_a;
        fail_b_d = fail_b;
        mismatch = (dut_eq !== (dut_a == dut_b));
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = DRIVE;
                    idx_d    = '0;
                    err_d    = '0;
                    fail_a_d = '0;
                    fail_b_d = '0;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            DRIVE: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_count != '1) begin
                        err_d = err_count + EW'(1);
                    end
                    if (err_count == '0) begin
                        fail_a_d = dut_a;
                        fail_b_d = dut_b;
                    end
                end
                if (idx == '1) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    idx_d   = idx + IW'(1);
                    state_d = DRIVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_a    <= '0;
            fail_b    <= '0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            err_count <= err_d;
            fail_a    <= fail_a_d;
            fail_b    <= fail_b_d;
        end
    end

endmodule

// File: tb/tb_eq_selftest.sv
// Self-checking bench for eq_selftest: emulates good and faulty comparators
// and compares run results against a vector-by-vector reference.
module tb_eq_selftest;

    localparam int W = 2;
    localparam int N = 1 << (2 * W);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [W-1:0]    dut_a, dut_b;
    logic            dut_eq;
    logic            busy, done, pass;
    logic [2*W:0]    err_count;
    logic [W-1:0]    fail_a, fail_b;

    // Comparator behaviour: 0 good, 1 stuck-0, 2 stuck-1, 3 inverted, 4 random faults.
    int              mode = 0;
    logic [N-1:0]    badmask = '0;

    int errors = 0;
    int checks = 0;

    eq_selftest #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dut_a     (dut_a),
        .dut_b     (dut_b),
        .dut_eq    (dut_eq),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_a    (fail_a),
        .fail_b    (fail_b)
    );

    always #5 clk = ~clk;

    function automatic logic cmp_model(input int m, input int a, input int b);
        case (m)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return !(a == b);
            4:       return (a == b) ^ badmask[a * (1 << W) + b];
            default: return (a == b);
        endcase
    endfunction

    // Emulated comparator under test.
    always_comb dut_eq = cmp_model(mode, int'(dut_a), int'(dut_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Runs one full test; poke re-asserts start at busy cycle 10.
    task automatic do_run(input int m, input bit poke, input string tag);
        int exp_err, exp_fa, exp_fb, cyc;
        bit found, finished;
        mode = m;
        exp_err = 0; exp_fa = 0; exp_fb = 0; found = 0;
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                if (cmp_model(m, a, b) != (a == b)) begin
                    exp_err++;
                    if (!found) begin
                        exp_fa = a; exp_fb = b; found = 1;
                    end
                end
            end
        end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        finished = 0;
        for (int t = 0; t < 200; t++) begin
            if (busy) begin
                cyc++;
                start = (poke && cyc == 10) ? 1'b1 : 1'b0;
            end else if (done) begin
                finished = 1;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " finished"}, 32'(finished), 32'd1);
        check({tag, " busy_cycles"}, 32'(cyc), 32'(2 * N));
        check({tag, " err_count"}, 32'(err_count), 32'(exp_err));
        check({tag, " pass"}, 32'(pass), 32'(exp_err == 0));
        check({tag, " fail_a"}, 32'(fail_a), 32'(exp_fa));
        check({tag, " fail_b"}, 32'(fail_b), 32'(exp_fb));
        // Results and operands hold while idle in DONE.
        repeat (3) @(negedge clk);
        check({tag, " done_hold"}, 32'(done), 32'd1);
        check({tag, " err_hold"}, 32'(err_count), 32'(exp_err));
        check({tag, " a_hold"}, 32'(dut_a), 32'((1 << W) - 1));
        check({tag, " b_hold"}, 32'(dut_b), 32'((1 << W) - 1));
    endtask

    task automatic check_zero(input string tag);
        check({tag, " dut_a"}, 32'(dut_a), 32'd0);
        check({tag, " dut_b"}, 32'(dut_b), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " pass"}, 32'(pass), 32'd0);
        check({tag, " err_count"}, 32'(err_count), 32'd0);
        check({tag, " fail_a"}, 32'(fail_a), 32'd0);
        check({tag, " fail_b"}, 32'(fail_b), 32'd0);
    endtask

    initial begin
        #1;
        check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // Idle with start low must stay quiet.
        repeat (3) @(negedge clk);
        check("idle busy", 32'(busy), 32'd0);
        check("idle done", 32'(done), 32'd0);

        do_run(0, 0, "good");
        do_run(1, 0, "stuck0");
        do_run(2, 0, "stuck1");
        do_run(3, 0, "invert");
        do_run(2, 1, "poke");

        for (int r = 0; r < 4; r++) begin
            badmask = N'($urandom);
            do_run(4, 0, "random");
        end

        // Start held high: DONE restarts immediately, done lasts one cycle.
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        check("hold busy", 32'(busy), 32'd1);
        check("hold done", 32'(done), 32'd0);
        repeat (2 * N) @(negedge clk);
        check("hold done_pulse", 32'(done), 32'd1);
        @(negedge clk);
        check("hold restart", 32'(busy), 32'd1);
        check("hold done_low", 32'(done), 32'd0);
        start = 1'b0;
        repeat (2 * N) @(negedge clk);

        // Asynchronous reset in the middle of a faulty run.
        mode = 3;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (14) @(negedge clk);
        check("midrun err_nonzero", 32'(err_count != 0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clk) rst_n = 1'b1;
        do_run(2, 0, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
